// File: rtl/mtm_alu_deserializer.sv
// Serial-to-parallel front end for the MTM ALU: decodes 11-bit frames into
// {B, A, OP} packets, checking the CRC-4 and the OP code as the bits arrive.
module mtm_alu_deserializer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sin,
    output logic        out_valid,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [2:0]  out_op,
    output logic        out_err,
    output logic [2:0]  out_err_flags
);

    typedef enum logic {IDLE, RX} state_t;

    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        is_cmd_q, is_cmd_d;
    logic [7:0]  pay_q, pay_d;
    logic [3:0]  data_cnt_q, data_cnt_d;
    logic [3:0]  crc_q, crc_d;
    logic [63:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [2:0]  flags_q, flags_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [2:0]  op_q, op_d;

    // The leading '0' of a CMD payload stands in for the 1'b1 of the CRC string.
    logic       crc_in;
    logic       crc_fb;
    logic [3:0] crc_step;

    assign crc_in   = (is_cmd_q && bit_cnt_q == 4'd1) ? 1'b1 : sin;
    assign crc_fb   = crc_q[3] ^ crc_in;
    assign crc_step = {crc_q[2:0], 1'b0} ^ {2'b00, crc_fb, crc_fb};

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        is_cmd_d   = is_cmd_q;
        pay_d      = pay_q;
        data_cnt_d = data_cnt_q;
        crc_d      = crc_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        flags_d    = flags_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        case (state_q)
            IDLE: begin
                if (!sin) begin
                    state_d   = RX;
                    bit_cnt_d = 4'd0;
                end
            end
            RX: begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd0) begin
                    is_cmd_d = sin;
                end else if (bit_cnt_q <= 4'd8) begin
                    pay_d = {pay_q[6:0], sin};
                    // The CRC field itself (last 4 CMD bits) is not part of the CRC string.
                    if (!is_cmd_q || bit_cnt_q <= 4'd4) begin
                        crc_d = crc_step;
                    end
                end else begin
                    state_d = IDLE;
                    if (!sin) begin
                        err_d   = 1'b1;
                        flags_d = 3'b100;
                    end else if (!is_cmd_q) begin
                        if (data_cnt_q == 4'd8) begin
                            err_d   = 1'b1;
                            flags_d = 3'b100;
                        end else begin
                            data_cnt_d = data_cnt_q + 4'd1;
                            data_d     = {data_q[55:0], pay_q};
                        end
                    end else if (data_cnt_q != 4'd8) begin
                        err_d   = 1'b1;
                        flags_d = 3'b100;
                    end else if (pay_q[3:0] != crc_q) begin
                        err_d   = 1'b1;
                        flags_d = 3'b010;
                    end else if (pay_q[5]) begin
                        // Legal OPs {000,001,100,101} all have OP[1] clear.
                        err_d   = 1'b1;
                        flags_d = 3'b001;
                    end else begin
                        valid_d = 1'b1;
                        b_d     = data_q[63:32];
                        a_d     = data_q[31:0];
                        op_d    = pay_q[6:4];
                    end
                    if (err_d || valid_d) begin
                        data_cnt_d = 4'd0;
                        crc_d      = 4'd0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 4'd0;
            is_cmd_q   <= 1'b0;
            pay_q      <= 8'd0;
            data_cnt_q <= 4'd0;
            crc_q      <= 4'd0;
            data_q     <= 64'd0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            flags_q    <= 3'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            op_q       <= 3'd0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            is_cmd_q   <= is_cmd_d;
            pay_q      <= pay_d;
            data_cnt_q <= data_cnt_d;
            crc_q      <= crc_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            flags_q    <= flags_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_err       = err_q;
    assign out_err_flags = flags_q;
    assign out_a         = a_q;
    assign out_b         = b_q;
    assign out_op        = op_q;

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Bench for mtm_alu_deserializer: directed and random frame streams checked
// against a frame-level packet model.
module tb_mtm_alu_deserializer;

    logic        clk;
    logic        rst_n;
    logic        sin;
    logic        out_valid;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [2:0]  out_op;
    logic        out_err;
    logic [2:0]  out_err_flags;

    mtm_alu_deserializer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sin           (sin),
        .out_valid     (out_valid),
        .out_a         (out_a),
        .out_b         (out_b),
        .out_op        (out_op),
        .out_err       (out_err),
        .out_err_flags (out_err_flags)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // scoreboard: {valid, err, flags} expected at each frame end
    logic [4:0]  exp_q[$];
    logic [7:0]  m_bytes[$];
    logic [31:0] m_a, m_b;
    logic [2:0]  m_op, m_flags;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // CRC-4 (x^4+x+1) as the remainder of polynomial long division of s * x^4.
    function automatic logic [3:0] crc4(input logic [67:0] s);
        logic [71:0] r;
        r = {s, 4'b0000};
        for (int i = 71; i >= 4; i--) begin
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        end
        return r[3:0];
    endfunction

    function automatic logic [7:0] make_cmd(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op, input logic [3:0] crc_xor);
        return {1'b0, op, crc4({b, a, 1'b1, op}) ^ crc_xor};
    endfunction

    task automatic model_frame(input logic typ, input logic [7:0] pay, input logic stp);
        logic        v, e;
        logic [2:0]  fl;
        logic [31:0] a, b;
        logic [2:0]  op;
        v = 1'b0; e = 1'b0; fl = 3'b000;
        if (!stp) begin
            e = 1'b1; fl = 3'b100;
        end else if (!typ) begin
            if (m_bytes.size() == 8) begin
                e = 1'b1; fl = 3'b100;
            end else begin
                m_bytes.push_back(pay);
            end
        end else if (m_bytes.size() != 8) begin
            e = 1'b1; fl = 3'b100;
        end else begin
            b  = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
            a  = {m_bytes[4], m_bytes[5], m_bytes[6], m_bytes[7]};
            op = pay[6:4];
            if (crc4({b, a, 1'b1, op}) != pay[3:0]) begin
                e = 1'b1; fl = 3'b010;
            end else if (!(op inside {3'b000, 3'b001, 3'b100, 3'b101})) begin
                e = 1'b1; fl = 3'b001;
            end else begin
                v = 1'b1; m_a = a; m_b = b; m_op = op;
            end
        end
        if (e) m_flags = fl;
        if (v || e) m_bytes.delete();
        exp_q.push_back({v, e, m_flags});
    endtask

    // driver tasks: drive on negedge, observe on the following negedge
    task automatic tick(input logic b);
        sin = b;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic quiet_bit(input logic b);
        tick(b);
        check_eq("quiet", 64'({out_valid, out_err}), 64'd0);
    endtask

    task automatic send_frame(input logic typ, input logic [7:0] pay, input logic stp);
        logic [10:0] f;
        logic [4:0]  ex;
        f = {1'b0, typ, pay, stp};
        for (int i = 10; i >= 1; i--) quiet_bit(f[i]);
        tick(f[0]);
        model_frame(typ, pay, stp);
        ex = exp_q.pop_front();
        check_eq("out_valid", 64'(out_valid), 64'(ex[4]));
        check_eq("out_err", 64'(out_err), 64'(ex[3]));
        check_eq("out_err_flags", 64'(out_err_flags), 64'(ex[2:0]));
        check_eq("out_a", 64'(out_a), 64'(m_a));
        check_eq("out_b", 64'(out_b), 64'(m_b));
        check_eq("out_op", 64'(out_op), 64'(m_op));
    endtask

    task automatic send_data(input logic [31:0] a, input logic [31:0] b, input int n);
        logic [63:0] ba;
        ba = {b, a};
        for (int j = 0; j < n; j++) send_frame(1'b0, ba[63 - 8*j -: 8], 1'b1);
    endtask

    task automatic send_packet(input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] op, input logic [3:0] crc_xor);
        send_data(a, b, 8);
        send_frame(1'b1, make_cmd(a, b, op, crc_xor), 1'b1);
    endtask

    task automatic check_reset_state();
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_err", 64'(out_err), 64'd0);
        check_eq("rst_a", 64'(out_a), 64'd0);
        check_eq("rst_b", 64'(out_b), 64'd0);
        check_eq("rst_op", 64'(out_op), 64'd0);
        check_eq("rst_flags", 64'(out_err_flags), 64'd0);
    endtask

    task automatic model_reset();
        m_bytes.delete();
        m_a = '0; m_b = '0; m_op = '0; m_flags = '0;
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [63:0] ba;
        logic [2:0]  rop;
        logic [3:0]  rx;
        int          mode, n_data, bad_idx;

        rst_n = 1'b0;
        sin   = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state();
        rst_n = 1'b1;

        // first start bit right after reset release
        send_packet(32'h1111_1111, 32'h2222_2222, 3'b100, 4'h0);
        send_packet(32'h1111_1111, 32'h2222_2222, 3'b100, 4'h1);
        send_packet(32'h1111_1111, 32'h2222_2222, 3'b010, 4'h0);
        send_data(32'h1234_5678, 32'h9abc_def0, 9);
        send_packet(32'h0000_0000, 32'hffff_ffff, 3'b101, 4'h0);
        quiet_bit(1'b1);
        send_data(32'h0f0f_0f0f, 32'hf0f0_f0f0, 7);
        send_frame(1'b1, make_cmd(32'h0f0f_0f0f, 32'hf0f0_f0f0, 3'b000, 4'h0), 1'b1);

        // reset during data frame 5
        send_data(32'hdead_beef, 32'hcafe_f00d, 4);
        quiet_bit(1'b0);
        quiet_bit(1'b0);
        quiet_bit(1'b1);
        quiet_bit(1'b0);
        rst_n = 1'b0;
        sin   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        check_reset_state();
        rst_n = 1'b1;
        send_packet(32'h0000_0007, 32'h0000_0003, 3'b001, 4'h0);

        // random streams, including back-to-back packets
        for (int k = 0; k < 40; k++) begin
            ra  = $urandom;
            rb  = $urandom;
            rop = 3'($urandom_range(0, 7));
            mode = $urandom_range(0, 9);
            rx = (mode == 3) ? 4'($urandom_range(1, 15)) : 4'h0;
            n_data  = (mode == 0) ? 7 : (mode == 1) ? 9 : 8;
            bad_idx = (mode == 2) ? $urandom_range(0, n_data) : -1;
            ba = {rb, ra};
            for (int j = 0; j < n_data; j++) begin
                send_frame(1'b0, (j < 8) ? ba[63 - 8*j -: 8] : 8'($urandom),
                           (bad_idx == j) ? 1'b0 : 1'b1);
            end
            send_frame(1'b1, make_cmd(ra, rb, rop, rx), (bad_idx == n_data) ? 1'b0 : 1'b1);
            repeat ($urandom_range(0, 2)) quiet_bit(1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
